// File: rtl/intersection_lights_if.sv
// Command channel of the intersection controller: command strobe with fields,
// and the rejected-command pulse coming back.
interface intersection_lights_if #(
  parameter int NUM_DIR = 4,
  parameter int TIME_W  = 16
);
  localparam int DIR_W = $clog2(NUM_DIR);

  logic              cmd_valid_i;
  logic [2:0]        cmd_type_i;
  logic [DIR_W-1:0]  cmd_dir_i;
  logic [TIME_W-1:0] cmd_data_i;
  logic              cmd_err_o;

  modport master (
    output cmd_valid_i, cmd_type_i, cmd_dir_i, cmd_data_i,
    input  cmd_err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_type_i, cmd_dir_i, cmd_data_i,
    output cmd_err_o
  );
endinterface

// File: rtl/intersection_lights.sv
// Multi-approach traffic light controller: timed per-approach cycle plus
// manual (yellow blink) and off modes, with runtime-programmable durations.
module intersection_lights #(
  parameter int NUM_DIR              = 4,
  parameter int TIME_W               = 16,
  parameter int CYC_PER_MS           = 2,
  parameter int BLINK_HALF_PERIOD_MS = 3,
  parameter int GREEN_BLINK_HALVES   = 8,
  parameter int RED_YELLOW_MS        = 7,
  parameter int DEFAULT_CYC          = 10
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  intersection_lights_if.slave       cmd,
  output logic [NUM_DIR-1:0]         red_o,
  output logic [NUM_DIR-1:0]         yellow_o,
  output logic [NUM_DIR-1:0]         green_o,
  output logic [$clog2(NUM_DIR)-1:0] active_dir_o
);

  localparam int DIR_W     = $clog2(NUM_DIR);
  localparam int HALF_CYC  = BLINK_HALF_PERIOD_MS * CYC_PER_MS;
  localparam int BLINK_CYC = GREEN_BLINK_HALVES * HALF_CYC;
  localparam int RY_CYC    = RED_YELLOW_MS * CYC_PER_MS;
  localparam int FIX_W     = $clog2(((BLINK_CYC > RY_CYC) ? BLINK_CYC : RY_CYC) + 1);
  localparam int CNT_W     = (TIME_W > FIX_W) ? TIME_W : FIX_W;
  localparam int HALF_W    = $clog2(HALF_CYC + 1);
  localparam int unsigned NUM_DIR_U = NUM_DIR;

  typedef enum logic [2:0] {
    S_ALL_RED, S_RED_YELLOW, S_GREEN, S_GREEN_BLINK, S_YELLOW, S_MANUAL, S_OFF
  } state_e;

  typedef enum logic [2:0] {
    CMD_ON, CMD_OFF, CMD_MANUAL, CMD_SET_GREEN,
    CMD_SET_ALL_RED, CMD_SET_YELLOW, CMD_SKIP, CMD_RSVD
  } cmd_e;

  state_e            state_q, state_d;
  logic [DIR_W-1:0]  dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              ph_q, ph_d;
  logic              err_q, err_d;
  logic [TIME_W-1:0] all_red_q, all_red_d;
  logic [TIME_W-1:0] yellow_q, yellow_d;
  logic [TIME_W-1:0] green_q [NUM_DIR];
  logic [TIME_W-1:0] green_d [NUM_DIR];

  logic              restart, idle, done, bad_set;
  logic [CNT_W-1:0]  dur;
  logic [31:0]       dir_ext;
  cmd_e              cmd_type;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    err_d     = 1'b0;
    all_red_d = all_red_q;
    yellow_d  = yellow_q;
    green_d   = green_q;
    restart   = 1'b0;
    cmd_type  = cmd_e'(cmd.cmd_type_i);
    dir_ext   = 32'(cmd.cmd_dir_i);
    idle      = (state_q == S_MANUAL) || (state_q == S_OFF);
    bad_set   = !idle || (cmd.cmd_data_i == '0);

    case (state_q)
      S_ALL_RED:     dur = CNT_W'(all_red_q);
      S_RED_YELLOW:  dur = CNT_W'(RY_CYC);
      S_GREEN:       dur = CNT_W'(green_q[dir_q]);
      S_GREEN_BLINK: dur = CNT_W'(BLINK_CYC);
      S_YELLOW:      dur = CNT_W'(yellow_q);
      default:       dur = '0;
    endcase
    done = !idle && (cnt_q == dur - CNT_W'(1));

    if (done) begin
      case (state_q)
        S_ALL_RED:     state_d = (RY_CYC > 0) ? S_RED_YELLOW : S_GREEN;
        S_RED_YELLOW:  state_d = S_GREEN;
        S_GREEN:       state_d = S_GREEN_BLINK;
        S_GREEN_BLINK: state_d = S_YELLOW;
        S_YELLOW: begin
          state_d = S_ALL_RED;
          dir_d   = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
        end
        default:       state_d = state_q;
      endcase
    end

    // Commands are decoded after the timed step so OFF/MANUAL/SKIP win over it;
    // rejected commands leave the timed progression untouched.
    if (cmd.cmd_valid_i) begin
      case (cmd_type)
        CMD_ON: begin
          if (idle) begin
            state_d = S_ALL_RED;
            dir_d   = '0;
          end
        end
        CMD_OFF: begin
          state_d = S_OFF;
          restart = 1'b1;
        end
        CMD_MANUAL: begin
          state_d = S_MANUAL;
          restart = 1'b1;
        end
        CMD_SET_GREEN: begin
          if (bad_set || (dir_ext >= 32'(NUM_DIR))) err_d = 1'b1;
          else green_d[cmd.cmd_dir_i] = cmd.cmd_data_i;
        end
        CMD_SET_ALL_RED: begin
          if (bad_set) err_d = 1'b1;
          else all_red_d = cmd.cmd_data_i;
        end
        CMD_SET_YELLOW: begin
          if (bad_set) err_d = 1'b1;
          else yellow_d = cmd.cmd_data_i;
        end
        CMD_SKIP: begin
          if (state_q == S_GREEN) state_d = S_GREEN_BLINK;
        end
        default: err_d = 1'b1;
      endcase
    end

    if ((state_d != state_q) || restart) begin
      cnt_d  = '0;
      half_d = '0;
      ph_d   = 1'b0;
    end else begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (half_q == HALF_W'(HALF_CYC - 1)) begin
        half_d = '0;
        ph_d   = ~ph_q;
      end else begin
        half_d = half_q + HALF_W'(1);
        ph_d   = ph_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= S_ALL_RED;
      dir_q     <= '0;
      cnt_q     <= '0;
      half_q    <= '0;
      ph_q      <= 1'b0;
      err_q     <= 1'b0;
      all_red_q <= TIME_W'(DEFAULT_CYC);
      yellow_q  <= TIME_W'(DEFAULT_CYC);
      for (int unsigned i = 0; i < NUM_DIR_U; i++) green_q[i] <= TIME_W'(DEFAULT_CYC);
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      ph_q      <= ph_d;
      err_q     <= err_d;
      all_red_q <= all_red_d;
      yellow_q  <= yellow_d;
      green_q   <= green_d;
    end
  end

  always_comb begin
    red_o    = '1;
    yellow_o = '0;
    green_o  = '0;
    case (state_q)
      S_RED_YELLOW: yellow_o[dir_q] = 1'b1;
      S_GREEN: begin
        red_o[dir_q]   = 1'b0;
        green_o[dir_q] = 1'b1;
      end
      S_GREEN_BLINK: begin
        red_o[dir_q]   = 1'b0;
        green_o[dir_q] = ph_q;
      end
      S_YELLOW: begin
        red_o[dir_q]    = 1'b0;
        yellow_o[dir_q] = 1'b1;
      end
      S_MANUAL: begin
        red_o    = '0;
        yellow_o = {NUM_DIR{ph_q}};
      end
      S_OFF:   red_o = '0;
      default: red_o = '1;
    endcase
  end

  assign active_dir_o  = dir_q;
  assign cmd.cmd_err_o = err_q;

endmodule

// File: tb/tb_intersection_lights.sv
// Scoreboard bench: each stimulus cycle queues the lamp/dir/err word expected
// after the next clock edge; a monitor pops and compares it just after the edge.
module tb_intersection_lights;

  localparam int P_AR = 0, P_RY = 1, P_G = 2, P_GB = 3, P_Y = 4, P_MAN = 5, P_OFF = 6;
  localparam logic [2:0] C_ON = 3'd0, C_OFF = 3'd1, C_MAN = 3'd2, C_SETG = 3'd3,
                         C_SETAR = 3'd4, C_SETY = 3'd5, C_SKIP = 3'd6, C_RSVD = 3'd7;

  typedef struct {
    bit          which;
    logic [14:0] exp;
    string       tag;
  } sb_t;

  logic clk = 1'b0;
  logic arst_n, rst2_n;
  logic [3:0] r1, y1, g1, r2, y2, g2;
  logic [1:0] ad1, ad2;
  int vectors = 0;
  int miscompares = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;

  intersection_lights_if #(.NUM_DIR(4), .TIME_W(16)) ifc1 ();
  intersection_lights_if #(.NUM_DIR(4), .TIME_W(16)) ifc2 ();

  intersection_lights #(.NUM_DIR(4), .TIME_W(16)) dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .cmd(ifc1.slave),
    .red_o(r1), .yellow_o(y1), .green_o(g1), .active_dir_o(ad1)
  );

  intersection_lights #(.NUM_DIR(4), .TIME_W(16), .RED_YELLOW_MS(0)) dut2 (
    .clk_i(clk), .arst_n_i(rst2_n), .cmd(ifc2.slave),
    .red_o(r2), .yellow_o(y2), .green_o(g2), .active_dir_o(ad2)
  );

  wire [14:0] obs1 = {ad1, r1, y1, g1, ifc1.cmd_err_o};
  wire [14:0] obs2 = {ad2, r2, y2, g2, ifc2.cmd_err_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_out(input int st, input int dir, input bit on, input bit err);
    logic [3:0] r, y, g;
    r = '1; y = '0; g = '0;
    case (st)
      P_RY:  y[dir] = 1'b1;
      P_G:   begin r[dir] = 1'b0; g[dir] = 1'b1; end
      P_GB:  begin r[dir] = 1'b0; g[dir] = on; end
      P_Y:   begin r[dir] = 1'b0; y[dir] = 1'b1; end
      P_MAN: begin r = '0; y = {4{on}}; end
      P_OFF: r = '0;
      default: r = '1;
    endcase
    return {2'(dir), r, y, g, err};
  endfunction

  function automatic bit blink_on(input int idx);
    return ((idx / 6) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, 32'(e.which ? obs2 : obs1), 32'(e.exp));
    end
  end

  task automatic tick(input string tag, input bit which, input logic [14:0] e);
    sb_t s;
    s.which = which; s.exp = e; s.tag = tag;
    sbq.push_back(s);
    @(negedge clk);
  endtask

  task automatic phase(input string tag, input bit which, input int st, input int dir,
                       input int n, input int start);
    for (int i = 0; i < n; i++) tick(tag, which, exp_out(st, dir, blink_on(start + i), 1'b0));
  endtask

  task automatic cmd_tick(input string tag, input logic [2:0] t, input logic [1:0] d,
                          input logic [15:0] data, input logic [14:0] e);
    ifc1.cmd_valid_i = 1'b1;
    ifc1.cmd_type_i  = t;
    ifc1.cmd_dir_i   = d;
    ifc1.cmd_data_i  = data;
    tick(tag, 1'b0, e);
    ifc1.cmd_valid_i = 1'b0;
  endtask

  task automatic rotation(input int dir, input int ar_n, input int g_n, input int y_n);
    phase("all_red", 0, P_AR, dir, ar_n, 0);
    phase("red_yel", 0, P_RY, dir, 14, 0);
    phase("green",   0, P_G,  dir, g_n, 0);
    phase("blink",   0, P_GB, dir, 48, 0);
    phase("yellow",  0, P_Y,  dir, y_n, 0);
  endtask

  initial begin
    arst_n = 1'b0;
    rst2_n = 1'b0;
    ifc1.cmd_valid_i = 1'b0; ifc1.cmd_type_i = '0; ifc1.cmd_dir_i = '0; ifc1.cmd_data_i = '0;
    ifc2.cmd_valid_i = 1'b0; ifc2.cmd_type_i = '0; ifc2.cmd_dir_i = '0; ifc2.cmd_data_i = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(obs1), 32'(exp_out(P_AR, 0, 1'b0, 1'b0)));
    phase("rst_hold", 0, P_AR, 0, 2, 0);

    // Defaults: full rotation over all four approaches, wrapping to 0.
    arst_n = 1'b1;
    rotation(0, 9, 10, 10);
    cmd_tick("skip_ign", C_SKIP, 2'd0, 16'd0, exp_out(P_AR, 1, 1'b0, 1'b0));
    phase("all_red", 0, P_AR, 1, 9, 0);
    phase("red_yel", 0, P_RY, 1, 14, 0);
    cmd_tick("on_ign", C_ON, 2'd0, 16'd0, exp_out(P_G, 1, 1'b0, 1'b0));
    phase("green", 0, P_G, 1, 9, 0);
    phase("blink", 0, P_GB, 1, 48, 0);
    phase("yellow", 0, P_Y, 1, 10, 0);
    rotation(2, 10, 10, 10);
    rotation(3, 10, 10, 10);
    phase("wrap_ar", 0, P_AR, 0, 10, 0);
    phase("red_yel", 0, P_RY, 0, 14, 0);

    // SET in GREEN rejected, SKIP at green cycle 3, OFF during blink.
    tick("green", 0, exp_out(P_G, 0, 1'b0, 1'b0));
    cmd_tick("sety_rej", C_SETY, 2'd0, 16'd30, exp_out(P_G, 0, 1'b0, 1'b1));
    phase("green", 0, P_G, 0, 2, 0);
    cmd_tick("skip", C_SKIP, 2'd0, 16'd0, exp_out(P_GB, 0, 1'b0, 1'b0));
    phase("blink", 0, P_GB, 0, 9, 1);
    cmd_tick("off", C_OFF, 2'd0, 16'd0, exp_out(P_OFF, 0, 1'b0, 1'b0));
    phase("off", 0, P_OFF, 0, 3, 0);

    // MANUAL blink, restart, SET commands, then ON.
    cmd_tick("manual", C_MAN, 2'd0, 16'd0, exp_out(P_MAN, 0, blink_on(0), 1'b0));
    phase("man", 0, P_MAN, 0, 8, 1);
    cmd_tick("man_restart", C_MAN, 2'd0, 16'd0, exp_out(P_MAN, 0, blink_on(0), 1'b0));
    phase("man", 0, P_MAN, 0, 6, 1);
    cmd_tick("setar_zero", C_SETAR, 2'd0, 16'd0, exp_out(P_MAN, 0, blink_on(7), 1'b1));
    cmd_tick("setg2", C_SETG, 2'd2, 16'd20, exp_out(P_MAN, 0, blink_on(8), 1'b0));
    cmd_tick("rsvd", C_RSVD, 2'd0, 16'd5, exp_out(P_MAN, 0, blink_on(9), 1'b1));
    tick("man", 0, exp_out(P_MAN, 0, blink_on(10), 1'b0));
    cmd_tick("on", C_ON, 2'd0, 16'd0, exp_out(P_AR, 0, 1'b0, 1'b0));
    rotation(0, 9, 10, 10);
    rotation(1, 10, 10, 10);
    rotation(2, 10, 20, 4);

    // Asynchronous reset in the middle of YELLOW.
    arst_n = 1'b0;
    #1;
    check("rst_mid", 32'(obs1), 32'(exp_out(P_AR, 0, 1'b0, 1'b0)));
    @(negedge clk);
    tick("rst_hold2", 0, exp_out(P_AR, 0, 1'b0, 1'b0));
    arst_n = 1'b1;
    phase("all_red2", 0, P_AR, 0, 9, 0);
    phase("red_yel2", 0, P_RY, 0, 1, 0);

    // No red+yellow phase: ALL_RED straight to GREEN.
    rst2_n = 1'b1;
    phase("nory_ar", 1, P_AR, 0, 9, 0);
    phase("nory_g", 1, P_G, 0, 10, 0);
    phase("nory_gb", 1, P_GB, 0, 2, 0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intersection_lights.md
INTERSECTION_LIGHTS -- requirements
Module: intersection_lights

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4: number of approaches; legal range 2..16.
REQ-002 SHALL have parameter TIME_W, default 16: width of all duration registers and cmd_data_i.
REQ-003 SHALL have parameter CYC_PER_MS, default 2: clock cycles per millisecond (2000 Hz clock).
REQ-004 SHALL have parameter BLINK_HALF_PERIOD_MS, default 3: blink half-period in ms; must be >0.
REQ-005 SHALL have parameter GREEN_BLINK_HALVES, default 8: number of half-periods in green-blink; must be >0 and even.
REQ-006 SHALL have parameter RED_YELLOW_MS, default 7: red+yellow phase length in ms; may be 0.
REQ-007 SHALL have parameter DEFAULT_CYC, default 10: reset value of every duration register, in cycles.
REQ-008 SHALL have port clk_i, input, 1: the single clock.
REQ-009 SHALL have port arst_n_i, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-010 SHALL have port cmd_valid_i, input, 1: command strobe, one command per valid cycle.
REQ-011 SHALL have port cmd_type_i, input, 3: 0 ON, 1 OFF, 2 MANUAL, 3 SET_GREEN, 4 SET_ALL_RED, 5 SET_YELLOW, 6 SKIP, 7 reserved.
REQ-012 SHALL have port cmd_dir_i, input, clog2(NUM_DIR): target approach for SET_GREEN.
REQ-013 SHALL have port cmd_data_i, input, TIME_W: duration in cycles for SET_* commands.
REQ-014 SHALL have ports red_o, yellow_o and green_o, each output, NUM_DIR: per-approach lamps.
REQ-015 SHALL have port active_dir_o, output, clog2(NUM_DIR): approach currently served.
REQ-016 SHALL have port cmd_err_o, output, 1: one-cycle pulse flagging a rejected command.

Function
REQ-017 SHALL implement the states ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW, MANUAL and OFF.
REQ-018 SHALL decode outputs from registered state only; a state change caused by a command in cycle n SHALL be visible on the outputs in cycle n+1.
REQ-019 SHALL run the normal cycle ALL_RED -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW -> ALL_RED, skipping RED_YELLOW when RED_YELLOW_MS=0.
REQ-020 SHALL make each timed state last exactly its programmed cycle count: ALL_RED = all_red_cyc; RED_YELLOW = RED_YELLOW_MS*CYC_PER_MS; GREEN = green_cyc[active_dir]; GREEN_BLINK = GREEN_BLINK_HALVES*BLINK_HALF_PERIOD_MS*CYC_PER_MS; YELLOW = yellow_cyc.
REQ-021 SHALL increment active_dir modulo NUM_DIR on YELLOW -> ALL_RED, wrapping NUM_DIR-1 to 0.
REQ-022 SHALL drive lamps for approach d = active_dir as follows: RED_YELLOW red+yellow; GREEN green; GREEN_BLINK green off in even half-periods (0,2,..) and on in odd ones; YELLOW yellow. All other approaches, and every approach in ALL_RED, SHALL show red only.
REQ-023 SHALL, in MANUAL, set all red_o and green_o low and drive all yellow_o together, off in the first half-period and toggling every BLINK_HALF_PERIOD_MS*CYC_PER_MS cycles.
REQ-024 SHALL set all lamps to 0 in OFF.
REQ-025 SHALL accept OFF and MANUAL from any state, overriding the timed transition in the same cycle; re-issuing MANUAL SHALL restart the blink phase.
REQ-026 SHALL move from MANUAL or OFF to ALL_RED with active_dir=0 on ON; ON in any other state SHALL be ignored without error.
REQ-027 SHALL accept SET_* commands only in MANUAL or OFF, writing the register in the next cycle.
REQ-028 SHALL reject, with a cmd_err_o pulse in cycle n+1, a SET_* command issued in other states, a SET_* with cmd_data_i=0, a SET_GREEN with cmd_dir_i>=NUM_DIR, and type 7; a rejected command SHALL leave state unchanged.
REQ-029 SHALL, on SKIP in GREEN, move to GREEN_BLINK next cycle; SKIP in any other state SHALL be ignored without error.
REQ-030 SHALL clear all phase and blink counters on every state entry, and counters SHALL never wrap within a state.

Reset
REQ-031 SHALL, on arst_n_i low, immediately set the state to ALL_RED, active_dir_o to 0, all durations to DEFAULT_CYC, all counters to 0 and cmd_err_o to 0; red_o SHALL be all ones and yellow_o and green_o all zeros.
REQ-032 SHALL release reset synchronously on clk_i and SHALL let a mid-cycle reset abort any state, including MANUAL and OFF.

Verification
REQ-033 Reset release with defaults and NUM_DIR=4 -> dir0 red for 10 cycles, red+yellow 14, green 10, blink 48 (off/on every 6), yellow 10, then ALL_RED with active_dir_o=1.
REQ-034 MANUAL, then SET_GREEN dir=2 data=20, then ON -> dir2 GREEN lasts exactly 20 cycles while the others keep 10.
REQ-035 SET_YELLOW during GREEN, and SET_ALL_RED data=0 in MANUAL -> cmd_err_o pulses once each and the registers are unchanged.
REQ-036 SKIP at GREEN cycle 3 -> GREEN_BLINK the next cycle; OFF during blink -> all lamps 0 the next cycle.
REQ-037 Full rotation with active_dir=3 -> wraps to 0; arst_n_i asserted mid-YELLOW -> outputs immediately return to reset values.
REQ-038 Run with RED_YELLOW_MS=0 -> ALL_RED goes directly to GREEN.
